// File: rtl/sa_pkg.sv
// Shared types and widths for the systolic-array tile sequencer and core.
package sa_pkg;

    localparam int ROWS_DEF = 8;
    localparam int OPW      = 8;
    localparam int ACCW     = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/sa_seq_counter.sv
// Loadable down-counter with a zero flag; times the stream, flush
// and drain phases of a tile.
module sa_seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sa_tile_sequencer.sv
// Streams one tile of operands into the systolic core, waits out the
// array skew and drains the ROWS result beats to a ready/valid consumer.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int KMAX = 256,
    parameter int AW   = $clog2(KMAX),
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_ren,
    output logic [AW-1:0]        buf_raddr,
    input  logic [ROWS*OPW-1:0]  buf_a_rdata,
    input  logic [ROWS*OPW-1:0]  buf_w_rdata,
    output logic [ROWS*OPW-1:0]  core_ain,
    output logic [ROWS*OPW-1:0]  core_win,
    output logic                 core_inpvalid,
    output logic                 core_outread,
    input  logic [ROWS*ACCW-1:0] core_rout,
    input  logic [ROWS-1:0]      core_rvalid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ROWS*ACCW-1:0] res_data
);

    localparam int FW = $clog2(2 * ROWS);
    localparam int BW = $clog2(ROWS + 1);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [KW-1:0] k_eff;
    logic          start_acc;
    logic          str_zero;
    logic          fl_zero;
    logic          bt_zero;

    assign k_eff     = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    assign start_acc = (state_q == S_IDLE) && start && !abort;

    // All three phase counters are armed together when a tile is accepted.
    sa_seq_counter #(.W(KW)) u_stream (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (start_acc),
        .load_val_i(k_eff - KW'(1)),
        .dec_i     (state_q == S_STREAM),
        .zero_o    (str_zero)
    );

    sa_seq_counter #(.W(FW)) u_flush (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (start_acc),
        .load_val_i(FW'(2 * ROWS - 2)),
        .dec_i     (state_q == S_FLUSH),
        .zero_o    (fl_zero)
    );

    sa_seq_counter #(.W(BW)) u_beat (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (start_acc),
        .load_val_i(BW'(ROWS - 1)),
        .dec_i     (core_outread),
        .zero_o    (bt_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    state_d = (k_eff == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_STREAM;
            S_STREAM: if (str_zero) state_d = S_FLUSH;
            S_FLUSH:  if (fl_zero) state_d = S_DRAIN;
            S_DRAIN:  if (core_outread && bt_zero) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (start_acc) begin
            addr_d = '0;
        end else if (buf_ren) begin
            addr_d = addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign buf_ren       = (state_q == S_FETCH) ||
                           ((state_q == S_STREAM) && !str_zero);
    assign buf_raddr     = buf_ren ? addr_q : '0;
    assign core_inpvalid = (state_q == S_STREAM);
    assign core_ain      = core_inpvalid ? buf_a_rdata : '0;
    assign core_win      = core_inpvalid ? buf_w_rdata : '0;
    assign res_valid     = (state_q == S_DRAIN) && (core_rvalid != '0);
    assign core_outread  = res_valid && res_ready;
    assign res_data      = core_rout;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Directed bench for sa_tile_sequencer with a cycle-offset reference model.
module tb_sa_tile_sequencer;

    localparam int ROWS = 8;
    localparam int KMAX = 256;
    localparam int AW   = 8;
    localparam int KW   = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn, start, abort, res_ready;
    logic [KW-1:0]        k_len;
    logic                 busy, done, buf_ren, core_inpvalid;
    logic                 core_outread, res_valid;
    logic [AW-1:0]        buf_raddr;
    logic [ROWS*8-1:0]    buf_a_rdata, buf_w_rdata, core_ain, core_win;
    logic [ROWS*32-1:0]   core_rout, res_data;
    logic [ROWS-1:0]      core_rvalid, rv;

    sa_tile_sequencer #(.ROWS(ROWS), .KMAX(KMAX)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .k_len(k_len), .busy(busy), .done(done),
        .buf_ren(buf_ren), .buf_raddr(buf_raddr),
        .buf_a_rdata(buf_a_rdata), .buf_w_rdata(buf_w_rdata),
        .core_ain(core_ain), .core_win(core_win),
        .core_inpvalid(core_inpvalid), .core_outread(core_outread),
        .core_rout(core_rout), .core_rvalid(core_rvalid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    function automatic logic [63:0] pat_a(int i);
        logic [7:0] b;
        b = 8'(i);
        return {8{b}} ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    function automatic logic [63:0] pat_w(int i);
        logic [7:0] b;
        b = 8'(i * 5 + 3);
        return {8{b}} ^ 64'hA55A5AA5C33C3CC3;
    endfunction

    // Operand buffer: one-cycle read latency.
    logic [AW-1:0] rd_q = '0;
    always @(posedge clk) if (buf_ren) rd_q <= buf_raddr;
    assign buf_a_rdata = pat_a(int'(rd_q));
    assign buf_w_rdata = pat_w(int'(rd_q));

    // Core output side: holds a beat until outread pops it.
    int cb = 0;
    always @(posedge clk) if (core_outread) cb <= cb + 1;
    assign core_rout   = {8{32'(cb * 7 + 1)}};
    assign core_rvalid = rv;

    int n_pass = 0, n_tot = 0;
    int cyc = 0, done_cyc = -1;
    int n_ren = 0, n_inpv = 0, n_or = 0, n_done = 0;
    int addrq[$];
    bit armed = 0, bp_en = 0;
    int bpi = 0;
    bit m_act = 0, m_done = 0;
    int m_off = 0, m_k = 0, m_beats = 0;
    bit hold_q = 0;
    logic [ROWS*32-1:0] hold_d;
    int b_ren, b_inpv, b_or, b_done, b_q, s_cyc;

    task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    endtask

    task automatic tick();
        bit strm, drn, e_ren, e_rv, e_or;
        int e_addr;
        logic [63:0] e_ain, e_win;
        @(negedge clk);
        if (armed) begin
            strm   = m_act && m_off >= 2 && m_off <= m_k + 1;
            drn    = m_act && m_off >= m_k + 2 * ROWS + 1;
            e_ren  = m_act && m_off >= 1 && m_off <= m_k;
            e_addr = e_ren ? m_off - 1 : 0;
            e_ain  = strm ? pat_a(m_off - 2) : '0;
            e_win  = strm ? pat_w(m_off - 2) : '0;
            e_rv   = drn && (core_rvalid != '0);
            e_or   = e_rv && res_ready;
            chk("busy", 256'(busy), 256'(m_act || m_done));
            chk("done", 256'(done), 256'(m_done));
            chk("buf_ren", 256'(buf_ren), 256'(e_ren));
            chk("buf_raddr", 256'(buf_raddr), 256'(e_addr));
            chk("inpvalid", 256'(core_inpvalid), 256'(strm));
            chk("core_ain", 256'(core_ain), 256'(e_ain));
            chk("core_win", 256'(core_win), 256'(e_win));
            chk("res_valid", 256'(res_valid), 256'(e_rv));
            chk("outread", 256'(core_outread), 256'(e_or));
            if (e_rv) chk("res_data", res_data, core_rout);
            if (hold_q && res_valid) chk("stall_hold", res_data, hold_d);
            hold_q = res_valid && !res_ready;
            hold_d = res_data;
            n_ren  += int'(buf_ren);
            n_inpv += int'(core_inpvalid);
            n_or   += int'(core_outread);
            n_done += int'(done);
            if (buf_ren) addrq.push_back(int'(buf_raddr));
            if (done) done_cyc = cyc;
            if (!rstn) begin
                m_act = 0; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_act) begin
                if (abort) m_act = 0;
                else begin
                    if (e_or) m_beats++;
                    if (m_beats == ROWS) begin m_act = 0; m_done = 1; end
                    m_off++;
                end
            end else if (start && !abort) begin
                m_k = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
                if (m_k == 0) m_done = 1;
                else begin m_act = 1; m_off = 1; m_beats = 0; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bp_en) begin
            res_ready = (bpi % 4 == 0) || (bpi % 4 == 3);
            bpi++;
        end
    endtask

    task automatic snap();
        b_ren = n_ren; b_inpv = n_inpv; b_or = n_or;
        b_done = n_done; b_q = addrq.size();
    endtask

    task automatic wait_idle(int maxc, string nm);
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (!busy) return;
        end
        n_tot++;
        $display("FAIL %s_timeout busy=%0b after %0d cycles", nm, busy, maxc);
    endtask

    task automatic run_tile(int k, int maxc, string nm);
        snap();
        k_len = KW'(k);
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        wait_idle(maxc, nm);
    endtask

    initial begin
        rstn = 0; start = 0; abort = 0; k_len = '0;
        res_ready = 1; rv = 8'hFF;
        repeat (2) tick();
        rstn = 1;
        armed = 1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_ren", 256'(buf_ren), 256'(0));
        chk("rst_inpv", 256'(core_inpvalid), 256'(0));
        repeat (2) tick();

        run_tile(4, 100, "k4");
        chk("k4_latency", 256'(done_cyc - s_cyc), 256'(29));
        chk("k4_inpv", 256'(n_inpv - b_inpv), 256'(4));
        chk("k4_outread", 256'(n_or - b_or), 256'(8));
        chk("k4_nraddr", 256'(addrq.size() - b_q), 256'(4));
        for (int i = 0; i < 4 && b_q + i < addrq.size(); i++)
            chk("k4_raddr_seq", 256'(addrq[b_q + i]), 256'(i));

        run_tile(0, 10, "k0");
        chk("k0_latency", 256'(done_cyc - s_cyc), 256'(1));
        chk("k0_ren", 256'(n_ren - b_ren), 256'(0));
        chk("k0_inpv", 256'(n_inpv - b_inpv), 256'(0));

        start = 1; abort = 1; k_len = 9'd5;
        tick();
        start = 0; abort = 0;
        chk("start_abort_idle", 256'(busy), 256'(0));
        repeat (2) tick();

        rv = 8'h10; bp_en = 1; bpi = 0;
        run_tile(3, 200, "bp");
        bp_en = 0; res_ready = 1; rv = 8'hFF;
        chk("bp_beats", 256'(n_or - b_or), 256'(8));
        chk("bp_done", 256'(n_done - b_done), 256'(1));
        tick();

        snap();
        k_len = 9'd2; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 100 && n_or - b_or < 3; i++) tick();
        res_ready = 0; abort = 1;
        tick();
        abort = 0; res_ready = 1;
        chk("abort_idle", 256'(busy), 256'(0));
        repeat (20) tick();
        chk("abort_beats", 256'(n_or - b_or), 256'(3));
        chk("abort_nodone", 256'(n_done - b_done), 256'(0));

        snap();
        k_len = 9'd300; start = 1; s_cyc = cyc;
        tick();
        start = 0;
        repeat (5) tick();
        start = 1; k_len = 9'd5;
        tick();
        start = 0;
        wait_idle(400, "clamp");
        chk("clamp_inpv", 256'(n_inpv - b_inpv), 256'(256));
        chk("clamp_latency", 256'(done_cyc - s_cyc), 256'(281));
        chk("clamp_done", 256'(n_done - b_done), 256'(1));
        tick();

        k_len = 9'd16; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        rstn = 0;
        tick();
        rstn = 1;
        chk("mrst_busy", 256'(busy), 256'(0));
        chk("mrst_done", 256'(done), 256'(0));
        chk("mrst_ren", 256'(buf_ren), 256'(0));
        chk("mrst_raddr", 256'(buf_raddr), 256'(0));
        chk("mrst_inpv", 256'(core_inpvalid), 256'(0));
        chk("mrst_outread", 256'(core_outread), 256'(0));
        chk("mrst_rvalid", 256'(res_valid), 256'(0));
        chk("mrst_ain", 256'({core_ain, core_win}), 256'(0));
        run_tile(2, 100, "post_rst");
        chk("post_rst_done", 256'(n_done - b_done), 256'(1));
        chk("post_rst_latency", 256'(done_cyc - s_cyc), 256'(27));
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sa_tile_sequencer.md
# sa_tile_sequencer

Sequences one matrix tile through the systolic array core. On `start` it reads `k_len` activation/weight vectors from an on-chip operand buffer, streams them into the core with `inpvalid`, waits for the array skew to flush, then drains `ROWS` result beats from the core to a downstream ready/valid consumer. It sits between the operand buffers and the core and owns the core's `inpvalid`/`outread` strobes.

## Interface
Parameters:
- `ROWS`, 8, array dimension (rows = columns)
- `KMAX`, 256, maximum reduction length per tile
- `AW`, $clog2(KMAX), buffer address width
- `KW`, $clog2(KMAX+1), width of `k_len`

Ports:
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  synchronous, active-low reset
- `start`  in  1  begin a tile; honoured only in IDLE
- `abort`  in  1  cancel the current tile; returns to IDLE
- `k_len`  in  KW  reduction length; sampled on accepted `start`; values > KMAX are clamped to KMAX
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on tile completion
- `buf_ren`  out  1  operand buffer read enable
- `buf_raddr`  out  AW  operand buffer address
- `buf_a_rdata`  in  ROWS×8  activation vector, valid 1 cycle after `buf_ren`
- `buf_w_rdata`  in  ROWS×8  weight vector, valid 1 cycle after `buf_ren`
- `core_ain`, `core_win`  out  ROWS×8  to core `ainport`/`winport`
- `core_inpvalid`  out  1  to core `inpvalid`
- `core_outread`  out  1  to core `outread`
- `core_rout`  in  ROWS×32  from core `routport`
- `core_rvalid`  in  ROWS  from core `rvalidport`
- `res_valid`  out  1  result beat valid
- `res_ready`  in  1  consumer accepts beat
- `res_data`  out  ROWS×32  result beat

## Operation
- States: IDLE, FETCH, STREAM, FLUSH, DRAIN, DONE.
- IDLE: `start` with `k_len`=0 → DONE (no reads, no `inpvalid`). `start` with `k_len`>0 → FETCH; latch `k_len`, clear the address and beat counters.
- FETCH (1 cycle): `buf_ren`=1, `buf_raddr`=0 → STREAM.
- STREAM (`k_len` cycles): `core_inpvalid`=1, `core_ain`/`core_win` = buffer read data. `buf_ren`=1 with address i+1 while i+1 < `k_len`. After the last vector → FLUSH.
- FLUSH (2·ROWS−1 cycles): `core_inpvalid`=0, then → DRAIN.
- DRAIN: `res_valid` = (`core_rvalid`≠0). `res_data` = `core_rout`, combinational pass-through. `core_outread` = `res_valid` & `res_ready`. Each handshake increments the beat counter; the ROWS-th beat → DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- `abort` in any non-IDLE state → IDLE next cycle, with no `done` pulse. All strobes are low in the abort cycle's successor. `abort` has priority over every other transition.
- `start` while `busy` is ignored. `start`+`abort` together in IDLE: `abort` wins and the state stays IDLE.
- `core_ain`/`core_win` are driven to 0 whenever `core_inpvalid`=0.

## Timing
- Reset values (while `rstn`=0 at an edge): state IDLE; `busy`, `done`, `buf_ren`, `core_inpvalid`, `core_outread`, `res_valid` = 0; `buf_raddr` = 0; `core_ain`/`core_win` = 0.
- `start` sampled at edge t: FETCH during t..t+1, first `core_inpvalid` in the cycle after FETCH, last `core_inpvalid` k_len−1 cycles later.
- Minimum tile latency from `start` to `done`, with `res_ready` tied high and results available: 1 + k_len + (2·ROWS−1) + ROWS + 1 cycles.
- `core_outread` is never asserted without `res_ready`. When `res_ready`=0, `res_data` holds its value (the core holds its output).
- Counters are sized to saturate-free: address counter AW bits, beat counter $clog2(ROWS+1) bits. No wrap-around within a legal tile.

## Structure
- A shared package `sa_pkg` holds: the state enum `seq_state_t`; the `ROWS` default; the data widths (8-bit operand, 32-bit accumulator) shared with the core.
- One sub-module, `sa_seq_counter`: a loadable down-counter with a zero flag. It is instantiated for the STREAM length, the FLUSH length and the DRAIN beats.

## Test plan
- Reset mid-STREAM (`k_len`=16, `rstn` low at cycle 5): the next cycle has every output at its reset value; a fresh `start` then runs to completion.
- `k_len`=4, ROWS=8, `res_ready`=1: `buf_raddr` sequence 0,1,2,3; `core_inpvalid` high exactly 4 cycles; exactly 8 `core_outread` pulses; `done` at cycle 1+4+15+8+1=29 after `start`.
- `k_len`=0: `done` exactly 1 cycle after `start`; `buf_ren` and `core_inpvalid` never asserted.
- Backpressure in DRAIN (`res_ready` toggling 1,0,0,1…): `core_outread` high only when `res_ready`=1; `res_data` stable while stalled; exactly 8 beats delivered.
- `abort` asserted in DRAIN after 3 beats: IDLE next cycle; no `done`; no further `core_outread`.
- `start` pulsed during STREAM, and `k_len`=300 with KMAX=256: the extra `start` is ignored; the clamp yields exactly 256 `inpvalid` cycles.
